// File: rtl/branch_ctrl.sv
// Branch/PC controller: RUN/FLUSH/HALT sequencing with one bubble per redirect.
// Optional return stack for CALL/RET is enabled by defining BRANCH_CTRL_RET_STACK_EN.
`timescale 1ns/1ps

module branch_ctrl #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter int         STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] opcode,
    input  logic [2:0] cond,
    input  logic [7:0] target,
    input  logic       stall,
    output logic [7:0] PC,
    output logic       taken,
    output logic       flush,
    output logic       halted
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam logic [4:0] OP_JMP  = 5'b10001;
    localparam logic [4:0] OP_BT   = 5'b10010;
    localparam logic [4:0] OP_BF   = 5'b10011;
    localparam logic [4:0] OP_CALL = 5'b10100;
    localparam logic [4:0] OP_RET  = 5'b10101;
    localparam logic [4:0] OP_HALT = 5'b11111;

    logic [1:0] state;
    logic       decode_en;
    logic       branch_hit;
    logic [7:0] branch_dest;
    logic       push_req;
    logic       pop_req;
    logic       stack_empty;
    logic [7:0] stack_top;

    // Only cond[0] carries the compare flag.
    logic unused_cond_bits;
    assign unused_cond_bits = ^cond[2:1];

    // An opcode is acted upon only in RUN with no stall.
    assign decode_en = (state == ST_RUN) && !stall;

`ifdef BRANCH_CTRL_RET_STACK_EN
    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(STACK_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STACK_DEPTH);

    logic [7:0]       stack_mem [STACK_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] top_idx;
    logic [CNT_W-1:0] count;

    // Circular buffer: wr_ptr is the next free slot, the entry below it is the top.
    assign wr_ptr_next = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
    assign top_idx     = (wr_ptr == '0) ? PTR_LAST : wr_ptr - 1'b1;
    assign stack_empty = (count == '0);
    assign stack_top   = stack_mem[top_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (decode_en && push_req) begin
            wr_ptr <= wr_ptr_next;
            // A push onto a full stack silently drops the oldest entry.
            if (count != CNT_FULL) begin
                count <= count + 1'b1;
            end
        end else if (decode_en && pop_req) begin
            wr_ptr <= top_idx;
            count  <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (decode_en && push_req) begin
            stack_mem[wr_ptr] <= PC;
        end
    end
`else
    logic unused_depth;
    assign unused_depth = (STACK_DEPTH > 0);
    assign stack_empty  = 1'b1;
    assign stack_top    = 8'h00;
`endif

    always_comb begin
        branch_hit  = 1'b0;
        branch_dest = target;
        push_req    = 1'b0;
        pop_req     = 1'b0;
        case (opcode)
            OP_JMP: branch_hit = 1'b1;
            OP_BT:  branch_hit = cond[0];
            OP_BF:  branch_hit = ~cond[0];
`ifdef BRANCH_CTRL_RET_STACK_EN
            OP_CALL: begin
                branch_hit = 1'b1;
                push_req   = 1'b1;
            end
            OP_RET: begin
                // Returning from an empty stack degrades to a plain advance.
                if (!stack_empty) begin
                    branch_hit  = 1'b1;
                    pop_req     = 1'b1;
                    branch_dest = stack_top;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_RUN;
            PC     <= RESET_PC;
            taken  <= 1'b0;
            flush  <= 1'b0;
            halted <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (stall) begin
                        taken <= 1'b0;
                    end else if (opcode == OP_HALT) begin
                        taken  <= 1'b0;
                        flush  <= 1'b0;
                        halted <= 1'b1;
                        state  <= ST_HALT;
                    end else if (branch_hit) begin
                        PC    <= branch_dest;
                        taken <= 1'b1;
                        flush <= 1'b1;
                        state <= ST_FLUSH;
                    end else begin
                        PC    <= PC + 8'd1;
                        taken <= 1'b0;
                        flush <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    // The opcode seen here was fetched from the wrong path.
                    taken <= 1'b0;
                    if (!stall) begin
                        PC    <= PC + 8'd1;
                        flush <= 1'b0;
                        state <= ST_RUN;
                    end
                end
                ST_HALT: begin
                    taken <= 1'b0;
                end
                default: begin
                    taken <= 1'b0;
                    flush <= 1'b0;
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: driver pushes model predictions, monitor pops and compares.
`timescale 1ns/1ps

module tb_branch_ctrl;

    localparam logic [7:0] RESET_PC = 8'h00;
    localparam int         DEPTH    = 4;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_JMP  = 5'b10001;
    localparam logic [4:0] OP_BT   = 5'b10010;
    localparam logic [4:0] OP_BF   = 5'b10011;
    localparam logic [4:0] OP_CALL = 5'b10100;
    localparam logic [4:0] OP_RET  = 5'b10101;
    localparam logic [4:0] OP_HALT = 5'b11111;

    localparam int M_RUN   = 0;
    localparam int M_FLUSH = 1;
    localparam int M_HALT  = 2;

    logic       clk;
    logic       rst_n;
    logic [4:0] opcode;
    logic [2:0] cond;
    logic [7:0] target;
    logic       stall;
    logic [7:0] PC;
    logic       taken;
    logic       flush;
    logic       halted;

    branch_ctrl #(.RESET_PC(RESET_PC), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .cond(cond), .target(target),
        .stall(stall), .PC(PC), .taken(taken), .flush(flush), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [10:0] exp_q[$];

    // Reference model: PC, a mode, the taken pulse and a list-based return stack.
    logic [7:0] m_pc;
    int         m_mode;
    logic       m_taken;
    logic [7:0] m_stack[$];

    function automatic logic [10:0] dut_out();
        return {PC, taken, flush, halted};
    endfunction

    function automatic logic [10:0] model_out();
        return {m_pc, m_taken, (m_mode == M_FLUSH), (m_mode == M_HALT)};
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: actual pc=%02h taken=%0b flush=%0b halted=%0b, required pc=%02h taken=%0b flush=%0b halted=%0b",
                     name, $time, act[10:3], act[2], act[1], act[0], exp[10:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic model_reset();
        m_pc    = RESET_PC;
        m_mode  = M_RUN;
        m_taken = 1'b0;
        m_stack.delete();
    endtask

    task automatic model_step(input logic [4:0] op, input logic [2:0] c, input logic [7:0] tgt, input logic st);
        logic       tk;
        logic [7:0] dest;
        m_taken = 1'b0;
        if (m_mode == M_HALT || st) begin
            return;
        end
        if (m_mode == M_FLUSH) begin
            m_pc   = m_pc + 8'd1;
            m_mode = M_RUN;
            return;
        end
        tk   = 1'b0;
        dest = tgt;
        case (op)
            OP_JMP: tk = 1'b1;
            OP_BT:  tk = c[0];
            OP_BF:  tk = !c[0];
`ifdef BRANCH_CTRL_RET_STACK_EN
            OP_CALL: begin
                tk = 1'b1;
                if (m_stack.size() == DEPTH) void'(m_stack.pop_front());
                m_stack.push_back(m_pc);
            end
            OP_RET: begin
                if (m_stack.size() > 0) begin
                    tk   = 1'b1;
                    dest = m_stack.pop_back();
                end
            end
`endif
            default: ;
        endcase
        if (op == OP_HALT) begin
            m_mode = M_HALT;
        end else if (tk) begin
            m_pc    = dest;
            m_taken = 1'b1;
            m_mode  = M_FLUSH;
        end else begin
            m_pc = m_pc + 8'd1;
        end
    endtask

    task automatic step(input logic [4:0] op, input logic [2:0] c, input logic [7:0] tgt, input logic st);
        @(negedge clk);
        opcode = op;
        cond   = c;
        target = tgt;
        stall  = st;
        model_step(op, c, tgt, st);
        exp_q.push_back(model_out());
    endtask

    // Reset asserted mid-cycle; outputs must change without waiting for an edge.
    task automatic reset_mid();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        exp_q.delete();
        check("async_reset", dut_out(), model_out());
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        logic [10:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle_outputs", dut_out(), e);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [4:0] op;
        int         r;
        int         halt_cycles;
        rst_n  = 1'b0;
        opcode = OP_NOP;
        cond   = 3'b000;
        target = 8'h00;
        stall  = 1'b0;
        #2;
        model_reset();
        check("reset_state", dut_out(), model_out());
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) step(OP_NOP, 3'b000, 8'h00, 1'b0);

        step(OP_JMP, 3'b000, 8'h0F, 1'b0);
        step(OP_NOP, 3'b000, 8'h00, 1'b0);
        step(OP_BT,  3'b001, 8'h40, 1'b0);
        step(OP_NOP, 3'b000, 8'h00, 1'b0);
        step(OP_JMP, 3'b000, 8'h0F, 1'b0);
        step(OP_NOP, 3'b000, 8'h00, 1'b0);
        step(OP_BT,  3'b000, 8'h40, 1'b0);
        step(OP_BF,  3'b110, 8'h55, 1'b0);
        step(OP_NOP, 3'b000, 8'h00, 1'b0);
        step(OP_BF,  3'b001, 8'h66, 1'b0);

        step(OP_JMP, 3'b000, 8'hFE, 1'b0);
        step(OP_NOP, 3'b000, 8'h00, 1'b0);
        step(OP_NOP, 3'b000, 8'h00, 1'b0);
        step(OP_JMP, 3'b000, 8'h05, 1'b1);
        step(OP_JMP, 3'b000, 8'h05, 1'b1);
        step(OP_JMP, 3'b000, 8'h05, 1'b0);
        step(OP_NOP, 3'b000, 8'h00, 1'b1);
        step(OP_NOP, 3'b000, 8'h00, 1'b0);
        step(OP_JMP, 3'b000, 8'h07, 1'b0);
        step(OP_JMP, 3'b000, 8'h07, 1'b0);

        step(OP_JMP, 3'b000, 8'h20, 1'b0);
        step(OP_JMP, 3'b000, 8'h77, 1'b0);
        step(OP_HALT, 3'b000, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end
        reset_mid();
        step(OP_JMP, 3'b000, 8'h90, 1'b0);
        reset_mid();
        step(OP_NOP, 3'b000, 8'h00, 1'b0);

        step(OP_JMP,  3'b000, 8'h07, 1'b0);
        step(OP_NOP,  3'b000, 8'h00, 1'b0);
        step(OP_CALL, 3'b000, 8'h30, 1'b0);
        step(OP_NOP,  3'b000, 8'h00, 1'b0);
        step(OP_RET,  3'b000, 8'h00, 1'b0);
        step(OP_NOP,  3'b000, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(OP_CALL, 3'b000, 8'h40 + 8'(i * 16), 1'b0);
            step(OP_NOP,  3'b000, 8'h00, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            step(OP_RET, 3'b000, 8'h00, 1'b0);
            step(OP_NOP, 3'b000, 8'h00, 1'b0);
        end
        step(OP_RET, 3'b000, 8'h00, 1'b0);

        halt_cycles = 0;
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 15);
            if (r <= 5)       op = 5'($urandom_range(0, 16));
            else if (r == 6)  op = OP_JMP;
            else if (r <= 8)  op = OP_BT;
            else if (r <= 10) op = OP_BF;
            else if (r <= 12) op = OP_CALL;
            else if (r <= 14) op = OP_RET;
            else              op = ($urandom_range(0, 9) == 0) ? OP_HALT : OP_NOP;
            step(op, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), ($urandom_range(0, 4) == 0));
            if (m_mode == M_HALT) halt_cycles++;
            if (halt_cycles > 5 || $urandom_range(0, 199) == 0) begin
                reset_mid();
                halt_cycles = 0;
            end
        end

        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drained: actual %0d pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
